// File: rtl/spram_clr.sv
// Single-port RAM with byte write enables and a hardware clear sequencer.
// State | meaning: IDLE = normal access, CLEAR = zeroing one word per cycle, accesses ignored.
module spram_clr #(
    parameter int DW           = 32,
    parameter int AW           = 10,
    parameter int OREG         = 0,
    parameter int CLR_ON_RESET = 1
) (
    input  logic            clka,
    input  logic            rsta_n,
    input  logic            ena,
    input  logic [DW/8-1:0] wea,
    input  logic [AW-1:0]   addra,
    input  logic [DW-1:0]   dina,
    input  logic            clra,
    output logic [DW-1:0]   douta,
    output logic            rvalida,
    output logic            busya,
    output logic            clr_donea
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic            clr_done_q;

    logic [DW-1:0]   mem [0:DEPTH-1];
    logic [DW-1:0]   ram_q;
    logic            rd_v1;

    logic            acc;
    logic            wr_req;
    logic            rd_req;
    logic [NB-1:0]   mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;

    // Accesses are honoured only in IDLE and never while reset is held.
    assign acc    = (state == IDLE) && ena && rsta_n;
    assign wr_req = acc && (|wea);
    assign rd_req = acc && !(|wea);

    always_comb begin
        mem_we    = '0;
        mem_addr  = addra;
        mem_wdata = dina;
        if (state == CLEAR && rsta_n) begin
            mem_we    = '1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
        end else if (wr_req) begin
            mem_we = wea;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state      <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clra) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state      <= IDLE;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busya     = (state == CLEAR);
    assign clr_donea = clr_done_q;

    // No reset on the array or its read register so it maps onto block RAM.
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (rd_req) begin
            ram_q <= mem[addra];
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_req;
        end
    end

    generate
        if (OREG == 0) begin : g_noreg
            logic hold_zero;

            // ram_q cannot be reset, so douta is forced to zero until the first read after reset.
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    hold_zero <= 1'b1;
                end else if (rd_req) begin
                    hold_zero <= 1'b0;
                end
            end

            assign douta   = hold_zero ? '0 : ram_q;
            assign rvalida = rd_v1;
        end else begin : g_oreg
            logic [DW-1:0] dout_q;
            logic          rd_v2;

            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    dout_q <= '0;
                    rd_v2  <= 1'b0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) begin
                        dout_q <= ram_q;
                    end
                end
            end

            assign douta   = dout_q;
            assign rvalida = rd_v2;
        end
    endgenerate

endmodule

// File: tb/tb_spram_clr.sv
// Scoreboard bench for spram_clr: three instances (32b/1024/OREG0, 32b/16/OREG1, 8b/16/OREG1)
// exercised in parallel; a negedge monitor checks every rvalida against queued expectations.
module tb_spram_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] model [3][1024];

    // instance A: DW=32 AW=10 OREG=0
    logic        rst_a, ena_a, clr_a;
    logic [3:0]  wea_a;
    logic [9:0]  addr_a;
    logic [31:0] din_a, dout_a;
    logic        rv_a, busy_a, done_a;
    // instance B: DW=32 AW=4 OREG=1
    logic        rst_b, ena_b, clr_b;
    logic [3:0]  wea_b;
    logic [3:0]  addr_b;
    logic [31:0] din_b, dout_b;
    logic        rv_b, busy_b, done_b;
    // instance C: DW=8 AW=4 OREG=1
    logic        rst_c, ena_c, clr_c;
    logic [0:0]  wea_c;
    logic [3:0]  addr_c;
    logic [7:0]  din_c, dout_c;
    logic        rv_c, busy_c, done_c;

    spram_clr #(.DW(32), .AW(10), .OREG(0), .CLR_ON_RESET(1)) u_a (
        .clka(clk), .rsta_n(rst_a), .ena(ena_a), .wea(wea_a), .addra(addr_a), .dina(din_a),
        .clra(clr_a), .douta(dout_a), .rvalida(rv_a), .busya(busy_a), .clr_donea(done_a));

    spram_clr #(.DW(32), .AW(4), .OREG(1), .CLR_ON_RESET(1)) u_b (
        .clka(clk), .rsta_n(rst_b), .ena(ena_b), .wea(wea_b), .addra(addr_b), .dina(din_b),
        .clra(clr_b), .douta(dout_b), .rvalida(rv_b), .busya(busy_b), .clr_donea(done_b));

    spram_clr #(.DW(8), .AW(4), .OREG(1), .CLR_ON_RESET(1)) u_c (
        .clka(clk), .rsta_n(rst_c), .ena(ena_c), .wea(wea_c), .addra(addr_c), .dina(din_c),
        .clra(clr_c), .douta(dout_c), .rvalida(rv_c), .busya(busy_c), .clr_donea(done_c));

    function automatic int aw_of(int k);
        return (k == 0) ? 10 : 4;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [3:0] wmask(int k);
        return (k == 2) ? 4'b0001 : 4'b1111;
    endfunction

    function automatic logic [31:0] dout_of(int k);
        case (k)
            0:       return dout_a;
            1:       return dout_b;
            default: return {24'h0, dout_c};
        endcase
    endfunction

    function automatic logic rv_of(int k);
        case (k)
            0:       return rv_a;
            1:       return rv_b;
            default: return rv_c;
        endcase
    endfunction

    function automatic logic busy_of(int k);
        case (k)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic done_of(int k);
        case (k)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    task automatic push(int k, logic [31:0] d, int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic set_in(int k, logic en, logic [3:0] we, logic [9:0] addr, logic [31:0] din, logic clr);
        case (k)
            0: begin ena_a = en; wea_a = we; addr_a = addr; din_a = din; clr_a = clr; end
            1: begin ena_b = en; wea_b = we; addr_b = addr[3:0]; din_b = din; clr_b = clr; end
            default: begin ena_c = en; wea_c = we[0]; addr_c = addr[3:0]; din_c = din[7:0]; clr_c = clr; end
        endcase
    endtask

    task automatic set_rst(int k, logic v);
        case (k)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    task automatic model_clear(int k);
        for (int a = 0; a < 1024; a++) model[k][a] = 32'h0;
    endtask

    // One access cycle while the instance is IDLE; updates the model or queues the read result.
    task automatic step(int k, logic en, logic [3:0] we, logic [9:0] addr, logic [31:0] din, logic clr);
        logic [3:0] wm;
        int a;
        @(negedge clk);
        set_in(k, en, we, addr, din, clr);
        if (en) begin
            wm = we & wmask(k);
            a  = int'(addr) & ((1 << aw_of(k)) - 1);
            if (wm == 4'b0000) begin
                push(k, model[k][a], cyc + lat_of(k));
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (wm[i]) model[k][a][8*i +: 8] = din[8*i +: 8];
                end
            end
        end
    endtask

    task automatic idle(int k, int n);
        repeat (n) step(k, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0);
    endtask

    // Counts negedges until busya falls. Cleared via clra costs one extra cycle for the
    // IDLE->CLEAR edge. With poke set, a write of all-ones to 0x010 is attempted while busy.
    task automatic wait_idle(int k, int exp_n, string nm, logic poke);
        int n;
        int bound;
        n     = 0;
        bound = exp_n * 2 + 8;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (n == 1 && poke) set_in(k, 1'b1, 4'hF, 10'h010, 32'hFFFF_FFFF, 1'b0);
            else                set_in(k, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0);
            if (!busy_of(k)) break;
        end
        chk({nm, "_len"}, k, n, exp_n);
        chk({nm, "_done"}, k, {31'h0, done_of(k)}, 32'h1);
        @(negedge clk);
        chk({nm, "_done_once"}, k, {31'h0, done_of(k)}, 32'h0);
        chk({nm, "_busy_low"}, k, {31'h0, busy_of(k)}, 32'h0);
    endtask

    task automatic test_dut(int k);
        int d;
        int mid;
        d   = 1 << aw_of(k);
        mid = (k == 0) ? 500 : d / 2;

        wait_idle(k, d, "rst_clear", 1'b0);
        model_clear(k);
        step(k, 1'b1, 4'h0, 10'(d - 1), 32'h0, 1'b0);

        step(k, 1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF, 1'b0);
        step(k, 1'b1, 4'b0010, 10'h005, 32'h0000_1200, 1'b0);
        step(k, 1'b1, 4'h0, 10'h005, 32'h0, 1'b0);

        for (int i = 0; i < 4; i++) step(k, 1'b1, 4'hF, 10'(i), 32'h10 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(k, 1'b1, 4'h0, 10'(i), 32'h0, 1'b0);
        step(k, 1'b1, 4'hF, 10'h002, 32'h77, 1'b0);
        idle(k, 3);
        chk("hold_after_write", k, dout_of(k), 32'h13);

        // read issued together with clra completes with pre-clear data
        step(k, 1'b1, 4'hF, 10'h010, 32'h0BAD_F00D, 1'b0);
        step(k, 1'b1, 4'h0, 10'h003, 32'h0, 1'b1);
        model_clear(k);
        wait_idle(k, d + 1, "clra_clear", 1'b1);
        step(k, 1'b1, 4'h0, 10'h010, 32'h0, 1'b0);
        step(k, 1'b1, 4'h0, 10'h003, 32'h0, 1'b0);
        idle(k, 3);

        // reset in the middle of a clear restarts it from address 0
        step(k, 1'b1, 4'hF, 10'h007, 32'h5A5A_5A5A, 1'b0);
        step(k, 1'b1, 4'hF, 10'(d - 1), 32'hC3C3_C3C3, 1'b0);
        step(k, 1'b1, 4'h0, 10'h007, 32'h0, 1'b0);
        idle(k, 3);
        step(k, 1'b0, 4'h0, 10'h0, 32'h0, 1'b1);
        step(k, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0);
        repeat (mid - 1) @(negedge clk);
        chk("pre_rst_hold", k, dout_of(k), (k == 2) ? 32'h5A : 32'h5A5A_5A5A);
        chk("pre_rst_busy", k, {31'h0, busy_of(k)}, 32'h1);
        @(negedge clk);
        set_rst(k, 1'b0);
        #1;
        chk("rst_dout", k, dout_of(k), 32'h0);
        chk("rst_rvalid", k, {31'h0, rv_of(k)}, 32'h0);
        chk("rst_done", k, {31'h0, done_of(k)}, 32'h0);
        chk("rst_busy", k, {31'h0, busy_of(k)}, 32'h1);
        @(negedge clk);
        set_rst(k, 1'b1);
        wait_idle(k, d, "rerun", 1'b0);
        model_clear(k);
        step(k, 1'b1, 4'h0, 10'(d - 1), 32'h0, 1'b0);
        step(k, 1'b1, 4'h0, 10'h007, 32'h0, 1'b0);
        idle(k, 4);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rv_of(k)) begin
                if (qsize(k) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rvalid dut%0d: got rvalida with douta %h, required none (cycle %0d)",
                             k, dout_of(k), cyc);
                end else begin
                    pop(k, e);
                    chk("rdata", k, dout_of(k), e.data);
                    chk("rlatency", k, cyc, e.due);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0);
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_dout", k, dout_of(k), 32'h0);
            chk("reset_rvalid", k, {31'h0, rv_of(k)}, 32'h0);
            chk("reset_done", k, {31'h0, done_of(k)}, 32'h0);
            chk("reset_busy", k, {31'h0, busy_of(k)}, 32'h1);
        end
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        fork
            test_dut(0);
            test_dut(1);
            test_dut(2);
        join
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("sb_drained", k, qsize(k), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
